// File: rtl/gate_checker.sv
// Initiator-side self-checker for 2-input gates: sweeps {a,b} = 00..11, compares y_in with a selected truth table.
// Latency: done rises 4*(SETTLE+1) edges after start is accepted; an illegal gate_sel reaches done on the accept edge.
// Backpressure: none; start is ignored while busy, results are held as a level until the next accepted start or rst.
module gate_checker #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_count,
    output logic [3:0] fail_vec,
    output logic       sel_err
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [2:0] sel_q;
    logic [1:0] v;
    logic [3:0] cnt;

    logic       y_exp;
    logic       mismatch;
    logic [3:0] fail_vec_nxt;
    logic [2:0] fail_count_nxt;

    always_comb begin
        y_exp = 1'b0;
        case (sel_q)
            3'd0:    y_exp = a_out & b_out;
            3'd1:    y_exp = a_out | b_out;
            3'd2:    y_exp = ~(a_out & b_out);
            3'd3:    y_exp = ~(a_out | b_out);
            3'd4:    y_exp = a_out ^ b_out;
            3'd5:    y_exp = ~(a_out ^ b_out);
            default: y_exp = 1'b0;
        endcase
        mismatch       = (y_in != y_exp);
        fail_vec_nxt   = fail_vec | (4'(mismatch) << v);
        fail_count_nxt = fail_count + 3'(mismatch);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel_q      <= 3'd0;
            v          <= 2'd0;
            cnt        <= 4'd0;
            a_out      <= 1'b0;
            b_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= 3'd0;
            fail_vec   <= 4'd0;
            sel_err    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        fail_count <= 3'd0;
                        fail_vec   <= 4'd0;
                        pass       <= 1'b0;
                        a_out      <= 1'b0;
                        b_out      <= 1'b0;
                        v          <= 2'd0;
                        cnt        <= 4'd0;
                        if (gate_sel <= 3'd5) begin
                            sel_q   <= gate_sel;
                            sel_err <= 1'b0;
                            done    <= 1'b0;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end else begin
                            // Illegal function: report immediately without driving the gate.
                            sel_err <= 1'b1;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (cnt == SETTLE_C) begin
                        fail_vec   <= fail_vec_nxt;
                        fail_count <= fail_count_nxt;
                        cnt        <= 4'd0;
                        if (v == 2'd3) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            a_out <= 1'b0;
                            b_out <= 1'b0;
                            pass  <= (fail_count_nxt == 3'd0);
                        end else begin
                            v              <= v + 2'd1;
                            {a_out, b_out} <= v + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_checker.sv
// Directed bench for gate_checker: an AND gate or a stuck-at-0 gate drives y_in; expected results are queued at start and compared at done.
module tb_gate_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] gate_sel;
    logic       a_out, b_out, y_in;
    logic       busy, done, pass, sel_err;
    logic [2:0] fail_count;
    logic [3:0] fail_vec;
    logic       stuck0;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic       pass;
        logic [2:0] fail_count;
        logic [3:0] fail_vec;
        logic       sel_err;
        int         latency;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    assign y_in = stuck0 ? 1'b0 : (a_out & b_out);

    gate_checker #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .gate_sel(gate_sel),
        .a_out(a_out), .b_out(b_out), .y_in(y_in),
        .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .fail_vec(fail_vec), .sel_err(sel_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Truth tables indexed by {a,b}: bit i is the gate output for vector i.
    function automatic logic [3:0] table_of(input logic [2:0] sel);
        case (sel)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1110;
            3'd2:    return 4'b0111;
            3'd3:    return 4'b0001;
            3'd4:    return 4'b0110;
            3'd5:    return 4'b1001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic exp_t model(input logic [2:0] sel, input logic stuck);
        exp_t       e;
        logic [3:0] actual;
        logic [3:0] diff;
        actual = stuck ? 4'b0000 : 4'b1000;
        if (sel > 3'd5) begin
            e.pass = 1'b0; e.fail_count = 3'd0; e.fail_vec = 4'd0;
            e.sel_err = 1'b1; e.latency = 0;
        end else begin
            diff = table_of(sel) ^ actual;
            e.fail_vec   = diff;
            e.fail_count = 3'd0;
            for (int i = 0; i < 4; i++) e.fail_count += 3'(diff[i]);
            e.pass    = (diff == 4'd0);
            e.sel_err = 1'b0;
            e.latency = 12;
        end
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, ".busy"},  32'(busy), 32'd0);
        check({tag, ".done"},  32'(done), 32'd0);
        check({tag, ".pass"},  32'(pass), 32'd0);
        check({tag, ".ab"},    32'({a_out, b_out}), 32'd0);
        check({tag, ".fcnt"},  32'(fail_count), 32'd0);
        check({tag, ".fvec"},  32'(fail_vec), 32'd0);
        check({tag, ".selerr"}, 32'(sel_err), 32'd0);
    endtask

    // Pulse start, follow the sweep, then compare against the queued expectation.
    // restart_at >= 0 re-pulses start (with a different gate_sel) after that many edges.
    task automatic run(input string tag, input logic [2:0] sel, input logic stuck, input int restart_at);
        exp_t e;
        int   n;
        stuck0   = stuck;
        gate_sel = sel;
        start    = 1'b1;
        sb.push_back(model(sel, stuck));
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            if (n == restart_at) begin start = 1'b1; gate_sel = 3'd1; end
            else start = 1'b0;
            if (n == 1 || n == 4 || n == 7 || n == 10) begin
                check({tag, ".ab_seq"}, 32'({a_out, b_out}), 32'(n / 3));
                check({tag, ".busy_run"}, 32'(busy), 32'd1);
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        e = sb.pop_front();
        check({tag, ".latency"}, 32'(n), 32'(e.latency));
        check({tag, ".done"},    32'(done), 32'd1);
        check({tag, ".busy"},    32'(busy), 32'd0);
        check({tag, ".ab_idle"}, 32'({a_out, b_out}), 32'd0);
        check({tag, ".pass"},    32'(pass), 32'(e.pass));
        check({tag, ".fcnt"},    32'(fail_count), 32'(e.fail_count));
        check({tag, ".fvec"},    32'(fail_vec), 32'(e.fail_vec));
        check({tag, ".selerr"},  32'(sel_err), 32'(e.sel_err));
        @(posedge clk); #1;
        check({tag, ".done_held"}, 32'(done), 32'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; gate_sel = 3'd0; stuck0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        start = 1'b1;
        @(posedge clk); #1;
        check("reset_dominates_start", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        run("and_pass",   3'd0, 1'b0, -1);
        run("stuck0",     3'd0, 1'b1, -1);
        run("or_vs_and",  3'd1, 1'b0, -1);
        run("back2back",  3'd0, 1'b0, -1);
        run("nand_vs_and", 3'd2, 1'b0, -1);
        run("xnor_stuck", 3'd5, 1'b1, -1);
        run("illegal7",   3'd7, 1'b0, -1);
        run("illegal6",   3'd6, 1'b0, -1);
        run("clear_sel",  3'd0, 1'b0, -1);
        run("restart_ign", 3'd0, 1'b0, 5);

        // Abort a run with rst on the 7th edge after accept.
        stuck0 = 1'b0; gate_sel = 3'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs("abort");
        run("after_abort", 3'd0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
